// File: rtl/alarm_sequencer.sv
// Alarm sequencer: compares BCD time with the alarm time and sequences
// ringing, snooze, auto-stop and hold, driving the piezo melody enable.
module alarm_sequencer #(
    parameter int TICK_DIV   = 1000000,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk1mhz,
    input  logic       reset,
    input  logic       alm_en,
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_sec,
    input  logic [7:0] alm_hour,
    input  logic [7:0] alm_min,
    input  logic       stop_btn,
    input  logic       snooze_btn,
    output logic       piezo,
    output logic       ringing,
    output logic       snoozing,
    output logic [3:0] snooze_cnt,
    output logic [9:0] remain_sec
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZE, HOLD} state_t;

    state_t          state, state_n;
    logic [9:0]      remain_n;
    logic [3:0]      cnt_n;
    logic [PW-1:0]   presc, presc_n;
    logic [2:0]      stop_sync, snooze_sync;
    logic            stop_p, snooze_p, tick, match;

    // Two synchronizer stages plus one history stage for the edge detector.
    always_ff @(posedge clk1mhz or posedge reset) begin
        if (reset) begin
            stop_sync   <= '0;
            snooze_sync <= '0;
        end else begin
            stop_sync   <= {stop_sync[1:0], stop_btn};
            snooze_sync <= {snooze_sync[1:0], snooze_btn};
        end
    end

    assign stop_p   = stop_sync[1] & ~stop_sync[2];
    assign snooze_p = snooze_sync[1] & ~snooze_sync[2];

    assign match = alm_en & (cur_hour == alm_hour) & (cur_min == alm_min)
                 & (cur_sec == 8'h00);

    assign tick = (presc == PW'(TICK_DIV - 1));

    always_comb begin
        state_n  = state;
        remain_n = remain_sec;
        cnt_n    = snooze_cnt;
        if (!alm_en) begin
            state_n  = IDLE;
            remain_n = '0;
            cnt_n    = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (match) begin
                        state_n  = RINGING;
                        remain_n = 10'(RING_SEC);
                        cnt_n    = '0;
                    end
                end
                RINGING: begin
                    if (stop_p || (snooze_p && snooze_cnt >= 4'(MAX_SNOOZE))) begin
                        state_n  = HOLD;
                        remain_n = '0;
                    end else if (snooze_p) begin
                        state_n  = SNOOZE;
                        cnt_n    = snooze_cnt + 4'd1;
                        remain_n = 10'(SNOOZE_SEC);
                    end else if (tick) begin
                        if (remain_sec == 10'd1) begin
                            state_n  = HOLD;
                            remain_n = '0;
                        end else begin
                            remain_n = remain_sec - 10'd1;
                        end
                    end
                end
                SNOOZE: begin
                    if (stop_p) begin
                        state_n  = HOLD;
                        remain_n = '0;
                    end else if (tick) begin
                        if (remain_sec == 10'd1) begin
                            state_n  = RINGING;
                            remain_n = 10'(RING_SEC);
                        end else begin
                            remain_n = remain_sec - 10'd1;
                        end
                    end
                end
                default: begin
                    remain_n = '0;
                    if (!match) state_n = IDLE;
                end
            endcase
        end
    end

    // Any state change restarts the second timer, so entry always sees a full TICK_DIV.
    always_comb begin
        presc_n = '0;
        if ((state_n == RINGING || state_n == SNOOZE) && state_n == state && !tick)
            presc_n = presc + PW'(1);
    end

    always_ff @(posedge clk1mhz or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            presc      <= '0;
            piezo      <= 1'b0;
            ringing    <= 1'b0;
            snoozing   <= 1'b0;
            snooze_cnt <= '0;
            remain_sec <= '0;
        end else begin
            state      <= state_n;
            presc      <= presc_n;
            piezo      <= (state_n == RINGING);
            ringing    <= (state_n == RINGING);
            snoozing   <= (state_n == SNOOZE);
            snooze_cnt <= cnt_n;
            remain_sec <= remain_n;
        end
    end

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: directed scenarios with literal expectations,
// then randomized stimulus checked every cycle against a behavioural model.
module tb_alarm_sequencer;

    localparam int TD = 10;
    localparam int RS = 3;
    localparam int SS = 4;
    localparam int MS = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       alm_en = 1'b0;
    logic [7:0] cur_hour = 8'h07, cur_min = 8'h30, cur_sec = 8'h00;
    logic [7:0] alm_hour = 8'h07, alm_min = 8'h30;
    logic       stop_btn = 1'b0, snooze_btn = 1'b0;
    logic       piezo, ringing, snoozing;
    logic [3:0] snooze_cnt;
    logic [9:0] remain_sec;

    int tests = 0;
    int fails = 0;

    alarm_sequencer #(.TICK_DIV(TD), .RING_SEC(RS), .SNOOZE_SEC(SS), .MAX_SNOOZE(MS)) dut (
        .clk1mhz(clk), .reset(reset), .alm_en(alm_en),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .alm_hour(alm_hour), .alm_min(alm_min),
        .stop_btn(stop_btn), .snooze_btn(snooze_btn),
        .piezo(piezo), .ringing(ringing), .snoozing(snoozing),
        .snooze_cnt(snooze_cnt), .remain_sec(remain_sec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: modes, seconds left, and cycles elapsed since entering a mode.
    typedef enum {M_IDLE, M_RING, M_SNZ, M_HOLD} mode_t;
    mode_t m_mode, nm;
    int    m_rem, m_cnt, elapsed;
    bit [2:0] hs_stop, hs_snz;
    bit    p_stop, p_snz, m_match, m_tick;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = M_IDLE; m_rem = 0; m_cnt = 0; elapsed = 0;
            hs_stop = '0; hs_snz = '0;
        end else begin
            // A raw rise is seen two samples back and acted on at this edge.
            p_stop  = hs_stop[1] && !hs_stop[2];
            p_snz   = hs_snz[1] && !hs_snz[2];
            hs_stop = {hs_stop[1:0], stop_btn};
            hs_snz  = {hs_snz[1:0], snooze_btn};
            m_match = alm_en && cur_hour == alm_hour && cur_min == alm_min && cur_sec == 8'h00;
            elapsed++;
            m_tick = (m_mode == M_RING || m_mode == M_SNZ) && (elapsed % TD == 0);
            nm = m_mode;
            if (!alm_en) begin
                nm = M_IDLE; m_rem = 0; m_cnt = 0;
            end else begin
                case (m_mode)
                    M_IDLE: if (m_match) begin nm = M_RING; m_rem = RS; m_cnt = 0; end
                    M_RING: begin
                        if (p_stop || (p_snz && m_cnt == MS)) begin nm = M_HOLD; m_rem = 0; end
                        else if (p_snz) begin nm = M_SNZ; m_cnt++; m_rem = SS; end
                        else if (m_tick) begin
                            m_rem--;
                            if (m_rem == 0) nm = M_HOLD;
                        end
                    end
                    M_SNZ: begin
                        if (p_stop) begin nm = M_HOLD; m_rem = 0; end
                        else if (m_tick) begin
                            m_rem--;
                            if (m_rem == 0) begin nm = M_RING; m_rem = RS; end
                        end
                    end
                    default: if (!m_match) nm = M_IDLE;
                endcase
            end
            if ((nm == M_RING || nm == M_SNZ) && nm != m_mode) elapsed = 0;
            m_mode = nm;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("model_piezo", int'(piezo), int'(m_mode == M_RING));
            chk("model_ringing", int'(ringing), int'(m_mode == M_RING));
            chk("model_snoozing", int'(snoozing), int'(m_mode == M_SNZ));
            chk("model_snooze_cnt", int'(snooze_cnt), m_cnt);
            chk("model_remain_sec", int'(remain_sec), m_rem);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pin(input string name, input int r, input int s, input int c, input int rem);
        chk({name, "_ringing"}, int'(ringing), r);
        chk({name, "_piezo"}, int'(piezo), r);
        chk({name, "_snoozing"}, int'(snoozing), s);
        chk({name, "_cnt"}, int'(snooze_cnt), c);
        chk({name, "_remain"}, int'(remain_sec), rem);
    endtask

    task automatic retrigger();
        cur_sec = 8'h01; cyc(1);
        cur_sec = 8'h00; cyc(1);
    endtask

    initial begin
        alm_en = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cyc(1);  pin("ring_entry", 1, 0, 0, 3);
        cyc(10); pin("ring_sec2", 1, 0, 0, 2);
        cyc(10); pin("ring_sec1", 1, 0, 0, 1);
        cyc(9);  pin("ring_last", 1, 0, 0, 1);
        cyc(1);  pin("auto_stop", 0, 0, 0, 0);
        cyc(5);  pin("hold_match", 0, 0, 0, 0);

        retrigger(); pin("retrig", 1, 0, 0, 3);
        snooze_btn = 1'b1;
        cyc(2); pin("snz_latency", 1, 0, 0, 3);
        cyc(1); pin("snz1", 0, 1, 1, SS);
        snooze_btn = 1'b0;
        cyc(SS * TD - 1); pin("snz1_last", 0, 1, 1, 1);
        cyc(1); pin("rering1", 1, 0, 1, RS);
        snooze_btn = 1'b1; cyc(3); pin("snz2", 0, 1, 2, SS);
        snooze_btn = 1'b0; cyc(SS * TD); pin("rering2", 1, 0, 2, RS);
        snooze_btn = 1'b1; cyc(3); pin("snz_limit", 0, 0, 2, 0);
        snooze_btn = 1'b0; cyc(3);

        retrigger(); pin("both_ring", 1, 0, 0, 3);
        snooze_btn = 1'b1; cyc(3); snooze_btn = 1'b0;
        cyc(SS * TD); pin("both_pre", 1, 0, 1, RS);
        stop_btn = 1'b1; snooze_btn = 1'b1;
        cyc(3); pin("both_stop", 0, 0, 1, 0);
        stop_btn = 1'b0; snooze_btn = 1'b0; cyc(3);

        retrigger();
        snooze_btn = 1'b1; cyc(3); snooze_btn = 1'b0;
        cyc(5); pin("en_pre", 0, 1, 1, SS);
        alm_en = 1'b0; cyc(1); pin("en_drop", 0, 0, 0, 0);
        alm_en = 1'b1; cyc(1); pin("en_rearm", 1, 0, 0, RS);

        stop_btn = 1'b1; cyc(3); pin("held_stop", 0, 0, 0, 0);
        retrigger(); cyc(20); pin("held_one_pulse", 1, 0, 0, 1);
        cyc(75); stop_btn = 1'b0; cyc(3);

        retrigger(); cyc(4);
        #2 reset = 1'b1;
        #1 pin("async_reset", 0, 0, 0, 0);
        cyc(2); reset = 1'b0;
        cyc(1); pin("match_at_release", 1, 0, 0, RS);

        for (int i = 0; i < 4000; i++) begin
            cyc(1);
            alm_en     = ($urandom_range(0, 149) != 0);
            cur_hour   = ($urandom_range(0, 9) == 0) ? 8'h08 : 8'h07;
            cur_min    = ($urandom_range(0, 9) == 0) ? 8'h31 : 8'h30;
            cur_sec    = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 89));
            if ($urandom_range(0, 15) == 0) stop_btn = ~stop_btn;
            if ($urandom_range(0, 7) == 0) snooze_btn = ~snooze_btn;
            if ($urandom_range(0, 999) == 0) begin
                reset = 1'b1; cyc(1); reset = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
